avalon_fast_serial_mm_bridge: RTL and testbench
===============================================

AVALON_FAST_SERIAL_MM_BRIDGE -- requirements
Module: avalon_fast_serial_mm_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000: inter-byte timeout, in clk cycles, for a partially received frame.
REQ-002 Parameter ACK_BYTE, default 8'h4B: response byte sent on write completion.
REQ-003 clk  in  1  single clock; every register in the block is in this domain.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rx_data  in  8  received serial byte.
REQ-006 rx_valid  in  1  one-cycle strobe; rx_data is valid while it is high.
REQ-007 tx_data  out  8  response byte.
REQ-008 tx_valid  out  1  response byte pending.
REQ-009 tx_ready  in  1  transmitter accepts tx_data on a cycle where tx_valid and tx_ready are both high.
REQ-010 address  out  10  Avalon word address to the on-chip memory.
REQ-011 byteenable  out  4  held at 4'hF.
REQ-012 chipselect, write  out  1 each  Avalon access strobes.
REQ-013 clken  out  1  held at 1.
REQ-014 debugaccess  out  1  held at 1, so that memory writes are enabled.
REQ-015 writedata  out  32  write word.
REQ-016 readdata  in  32  memory output, valid on the cycle after a read strobe.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 err  out  1  one-cycle pulse on a bad command, a timeout, or an overrun.

Function
REQ-019 Frame format: cmd byte, addr_hi (bits [1:0] used, [7:2] ignored), addr_lo, then 4 data bytes, LSB first, for a write only.
REQ-020 cmd 8'h57 selects write and cmd 8'h52 selects read; any other cmd byte in IDLE is dropped with an err pulse, and the state stays IDLE.
REQ-021 States are IDLE, ADDR_HI, ADDR_LO, DATA, WR, RD, RD_CAP and TX.
- Receive path: IDLE->ADDR_HI->ADDR_LO, each on an rx_valid byte.
- Write: ADDR_LO->DATA; DATA advances a 2-bit byte counter and goes to WR on the 4th byte.
- Read: ADDR_LO->RD.
REQ-022 WR lasts exactly one cycle with chipselect=1, write=1, and address/writedata stable; the next state is TX with tx_data=ACK_BYTE.
REQ-023 RD lasts exactly one cycle with chipselect=1 and write=0; in RD_CAP the block latches readdata into a 32-bit shift register, then moves to TX.
REQ-024 Read latency is fixed: readdata is sampled exactly 1 cycle after the RD strobe cycle, with no wait-request.
REQ-025 TX holds tx_valid=1 and a stable tx_data until tx_ready.
- Read response: 4 bytes, LSB first; the shift register shifts by 8 on each accept.
- After the last accepted byte the state returns to IDLE on the next cycle.
REQ-026 tx_valid may be high for consecutive cycles; a byte is never presented twice and never skipped.
REQ-027 An rx_valid byte arriving in WR, RD, RD_CAP or TX is dropped and pulses err (overrun); the state is unaffected.
REQ-028 Timeout counter rules:
- Cleared on every accepted rx byte.
- Counts only in ADDR_HI, ADDR_LO and DATA.
- On reaching TIMEOUT_CYCLES-1: return to IDLE, pulse err, discard the partial frame, clear the byte counter.
REQ-029 If rx_valid and the timeout expiry occur on the same cycle, the byte wins: it is accepted and the counter is cleared.
REQ-030 chipselect and write are never high outside WR and RD; chipselect is high for exactly one cycle per frame.
REQ-031 Address 10'h3FF is valid, and there is no address wrap or auto-increment.

Reset
REQ-032 On reset assertion, asynchronously:
- State becomes IDLE.
- chipselect, write, tx_valid, err and busy become 0.
- address, writedata, tx_data and the shift register become 0.
- The byte and timeout counters become 0.
REQ-033 Reset asserted mid-frame or mid-TX aborts the frame: no memory write is issued and no further tx byte is presented.
REQ-034 After reset release, the first rx byte is interpreted as a cmd.

Verification
REQ-035 Write frame 57 03 FF 78 56 34 12 -> one cycle with chipselect=write=1, address=3FF, writedata=12345678; then tx_data 4B is presented once.
REQ-036 Read frame 52 00 05, with readdata=DEADBEEF on the cycle after the RD strobe -> tx bytes EF, BE, AD, DE in order, then busy=0.
REQ-037 tx_ready held low for 20 cycles during a read response -> tx_valid stays 1 and tx_data=EF is unchanged; no rx activity is lost in IDLE afterwards.
REQ-038 cmd 41 -> err pulse, state stays IDLE; a following valid read frame completes normally.
REQ-039 With TIMEOUT_CYCLES=16: send 57 00, then idle 16 cycles -> err pulse, state IDLE, no write strobe; the next frame decodes correctly.
REQ-040 Reset asserted on the 3rd data byte of a write frame -> no write strobe occurs and all outputs are 0.

Source files
------------

// File: rtl/avalon_fast_serial_mm_bridge.sv
// rtl/avalon_fast_serial_mm_bridge.sv - serial byte-frame to Avalon-MM bridge for on-chip memory
//
// Purpose: decodes write (57 hi lo d0 d1 d2 d3) and read (52 hi lo) frames from a
// byte stream, issues one Avalon access per frame, and returns an ACK byte (write)
// or the 4 read bytes LSB first (read) over a valid/ready transmit port.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   rx_data, rx_valid            received byte and its one-cycle strobe
//   tx_data, tx_valid, tx_ready  response byte handshake
//   address, byteenable, chipselect, write, clken, debugaccess, writedata, readdata
//                                Avalon-MM master toward the memory (1-cycle read latency)
//   busy                         high whenever a frame is in progress
//   err                          one-cycle pulse on bad command, timeout or overrun
module avalon_fast_serial_mm_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  ACK_BYTE       = 8'h4B
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [9:0]  address,
  output logic [3:0]  byteenable,
  output logic        chipselect,
  output logic        write,
  output logic        clken,
  output logic        debugaccess,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA, S_WR, S_RD, S_RD_CAP, S_TX
  } state_t;

  state_t        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [9:0]    addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   shreg_q, shreg_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [1:0]    tx_left_q, tx_left_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      shreg_q    <= '0;
      byte_cnt_q <= '0;
      tx_left_q  <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      tx_left_q  <= tx_left_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    shreg_d    = shreg_q;
    byte_cnt_d = byte_cnt_q;
    tx_left_d  = tx_left_q;
    tmo_d      = '0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == 8'h57) begin
            is_wr_d = 1'b1;
            state_d = S_ADDR_HI;
          end else if (rx_data == 8'h52) begin
            is_wr_d = 1'b0;
            state_d = S_ADDR_HI;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ADDR_HI: begin
        if (rx_valid) begin
          addr_d[9:8] = rx_data[1:0];
          state_d     = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (rx_valid) begin
          addr_d[7:0] = rx_data;
          byte_cnt_d  = '0;
          state_d     = is_wr_q ? S_DATA : S_RD;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          // Bytes arrive LSB first, so shift in from the top.
          wdata_d    = {rx_data, wdata_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = S_WR;
        end
      end
      S_WR: begin
        shreg_d   = {24'h0, ACK_BYTE};
        tx_left_d = 2'd0;
        state_d   = S_TX;
      end
      S_RD: state_d = S_RD_CAP;
      S_RD_CAP: begin
        // Memory has fixed one-cycle latency: readdata is valid now.
        shreg_d   = readdata;
        tx_left_d = 2'd3;
        state_d   = S_TX;
      end
      S_TX: begin
        if (tx_ready) begin
          shreg_d = {8'h00, shreg_q[31:8]};
          if (tx_left_q == 2'd0) state_d = S_IDLE;
          else tx_left_d = tx_left_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bytes arriving while the bridge is busy with the memory or the reply are lost.
    if (rx_valid && (state_q == S_WR || state_q == S_RD ||
                     state_q == S_RD_CAP || state_q == S_TX)) begin
      err_d = 1'b1;
    end

    // Inter-byte timeout; an arriving byte takes priority over expiry.
    if (state_q == S_ADDR_HI || state_q == S_ADDR_LO || state_q == S_DATA) begin
      if (rx_valid) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        tmo_d      = '0;
        byte_cnt_d = '0;
        err_d      = 1'b1;
        state_d    = S_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  assign chipselect  = (state_q == S_WR) || (state_q == S_RD);
  assign write       = (state_q == S_WR);
  assign tx_valid    = (state_q == S_TX);
  assign tx_data     = shreg_q[7:0];
  assign busy        = (state_q != S_IDLE);
  assign err         = err_q;
  assign address     = addr_q;
  assign writedata   = wdata_q;
  assign byteenable  = 4'hF;
  assign clken       = 1'b1;
  assign debugaccess = 1'b1;

endmodule

// File: tb/tb_avalon_fast_serial_mm_bridge.sv
// tb/tb_avalon_fast_serial_mm_bridge.sv - randomized self-checking bench for the serial MM bridge
module tb_avalon_fast_serial_mm_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [9:0]  address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        write;
  logic        clken;
  logic        debugaccess;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busy;
  logic        err;

  avalon_fast_serial_mm_bridge #(.TIMEOUT_CYCLES(16), .ACK_BYTE(8'h4B)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .write(write), .clken(clken), .debugaccess(debugaccess),
    .writedata(writedata), .readdata(readdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: expected memory contents.
  logic [31:0] exp_mem [0:1023];

  function automatic logic [31:0] init_val(input int i);
    if (i == 5) return 32'hDEADBEEF;
    return (i * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Synchronous memory with one-cycle read latency; readdata is junk otherwise.
  logic [31:0] ram [0:1023];
  bit ram_init_done = 1'b0;
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
      ram_init_done <= 1'b1;
    end else if (chipselect && write) begin
      ram[address] <= writedata;
    end
    readdata <= (chipselect && !write) ? ram[address] : $urandom;
  end

  // Monitor.
  int          cs_count = 0;
  int          wr_count = 0;
  int          err_count = 0;
  logic [9:0]  last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic [7:0]  txq [$];
  always @(posedge clk) begin
    if (chipselect) cs_count++;
    if (chipselect && write) begin
      wr_count++;
      last_wr_addr = address;
      last_wr_data = writedata;
    end
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (err) err_count++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic gap(input bit rnd);
    if (rnd) repeat ($urandom_range(0, 4)) step();
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [9:0] a, input bit rnd);
    logic [7:0] hi;
    hi = {6'($urandom), a[9:8]};
    send_byte(cmd); gap(rnd);
    send_byte(hi);  gap(rnd);
    send_byte(a[7:0]);
  endtask

  task automatic drain_tx(input int n, input bit rnd);
    int budget = 400;
    while (txq.size() < n && budget > 0) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      budget--;
    end
    tx_ready = 1'b0;
    if (budget == 0) check_eq("tx_wait", txq.size(), n);
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input bit rnd);
    int wc0, cs0, ec0;
    logic [31:0] dv;
    wc0 = wr_count; cs0 = cs_count; ec0 = err_count;
    dv = d;
    txq.delete();
    send_hdr(8'h57, a, rnd);
    for (int k = 0; k < 4; k++) begin
      gap(rnd);
      send_byte(dv[8*k +: 8]);
    end
    exp_mem[a] = d;
    drain_tx(1, rnd);
    step(); step();
    check_eq("wr_strobes", wr_count - wc0, 1);
    check_eq("wr_cs_cycles", cs_count - cs0, 1);
    check_eq("wr_addr", last_wr_addr, a);
    check_eq("wr_data", last_wr_data, d);
    check_eq("ack_count", txq.size(), 1);
    check_eq("ack_byte", txq.size() > 0 ? txq[0] : 8'h00, 8'h4B);
    check_eq("wr_no_err", err_count - ec0, 0);
    check_eq("wr_busy_end", busy, 0);
  endtask

  task automatic do_read(input logic [9:0] a, input bit rnd);
    int cs0, wc0, ec0;
    logic [31:0] e;
    cs0 = cs_count; wc0 = wr_count; ec0 = err_count;
    e = exp_mem[a];
    txq.delete();
    send_hdr(8'h52, a, rnd);
    drain_tx(4, rnd);
    check_eq("rd_busy_end", busy, 0);
    step();
    for (int k = 0; k < 4; k++)
      check_eq($sformatf("rd_byte%0d@%h", k, a), k < txq.size() ? txq[k] : 8'hxx, e[8*k +: 8]);
    check_eq("rd_count", txq.size(), 4);
    check_eq("rd_cs_cycles", cs_count - cs0, 1);
    check_eq("rd_no_write", wr_count - wc0, 0);
    check_eq("rd_no_err", err_count - ec0, 0);
  endtask

  initial begin
    int ec0, wc0;
    bit hold_ok;
    int budget;
    logic [9:0] ra;

    for (int i = 0; i < 1024; i++) exp_mem[i] = init_val(i);
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    step(); step(); step();
    check_eq("rst_outputs", {chipselect, write, tx_valid, err, busy, address, writedata, tx_data}, 0);
    check_eq("const_outputs", {byteenable, clken, debugaccess}, 6'b111111);
    reset = 1'b0;
    step();

    // Directed write frame 57 03 FF 78 56 34 12.
    do_write(10'h3FF, 32'h12345678, 1'b0);

    // Directed read 52 00 05 with back-to-back acceptance.
    do_read(10'h005, 1'b0);

    // Stall the first response byte, with an overrun byte during the stall.
    txq.delete();
    ec0 = err_count;
    send_hdr(8'h52, 10'h005, 1'b0);
    budget = 10;
    while (!tx_valid && budget > 0) begin step(); budget--; end
    check_eq("stall_first", tx_data, 8'hEF);
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) send_byte(8'h99);
      else step();
      if (!tx_valid || tx_data !== 8'hEF) hold_ok = 1'b0;
    end
    check_eq("stall_hold", hold_ok, 1);
    step();
    check_eq("overrun_err", err_count - ec0, 1);
    drain_tx(4, 1'b0);
    check_eq("stall_b0", txq.size() > 0 ? txq[0] : 8'h00, 8'hEF);
    check_eq("stall_b1", txq.size() > 1 ? txq[1] : 8'h00, 8'hBE);
    check_eq("stall_b2", txq.size() > 2 ? txq[2] : 8'h00, 8'hAD);
    check_eq("stall_b3", txq.size() > 3 ? txq[3] : 8'h00, 8'hDE);
    do_read(10'($urandom), 1'b0);

    // Bad command.
    ec0 = err_count;
    send_byte(8'h41);
    step();
    check_eq("badcmd_err", err_count - ec0, 1);
    check_eq("badcmd_idle", busy, 0);
    do_read(10'h123, 1'b1);

    // Timeout after 57 00.
    ec0 = err_count; wc0 = wr_count;
    send_byte(8'h57);
    send_byte(8'h00);
    repeat (15) step();
    check_eq("tmo_not_yet", {busy, 1'(err_count - ec0)}, 2'b10);
    step();
    check_eq("tmo_err_pulse", err, 1);
    check_eq("tmo_idle", busy, 0);
    step();
    check_eq("tmo_err_once", err_count - ec0, 1);
    check_eq("tmo_no_write", wr_count - wc0, 0);
    do_write(10'h040, 32'hCAFEF00D, 1'b0);

    // Byte arriving on the expiry cycle is accepted.
    txq.delete();
    ec0 = err_count;
    send_byte(8'h52);
    send_byte(8'h00);
    repeat (15) step();
    send_byte(8'h40);
    drain_tx(4, 1'b0);
    check_eq("tie_byte0", txq.size() > 0 ? txq[0] : 8'h00, 8'h0D);
    check_eq("tie_byte3", txq.size() > 3 ? txq[3] : 8'h00, 8'hCA);
    check_eq("tie_no_err", err_count - ec0, 0);

    // Reset on the 3rd data byte of a write frame.
    wc0 = wr_count;
    send_hdr(8'h57, 10'h010, 1'b0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rx_data = 8'hCC; rx_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_eq("rst_async", {chipselect, write, tx_valid, err, busy, address, writedata, tx_data}, 0);
    rx_valid = 1'b0;
    step(); step();
    check_eq("rst_held", {chipselect, write, tx_valid, err, busy, address, writedata, tx_data}, 0);
    reset = 1'b0;
    step();
    check_eq("rst_no_write", wr_count - wc0, 0);
    do_read(10'h010, 1'b0);

    // Randomized frames against the memory model.
    for (int n = 0; n < 30; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) do_write(ra, $urandom, 1'b1);
      else do_read(ra, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
